// File: rtl/state_report_pkg.sv
// Shared constants, FSM encoding and helpers for the state report encoder.
// Frame layout depends on `STATE_REPORT_CKSUM_EN (adds a checksum byte).
package state_report_pkg;

  localparam logic [7:0] CH_F  = 8'h66;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_Q  = 8'h3F;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StSend = SEND,
    StDone = DONE
  } fsm_e;

`ifdef STATE_REPORT_CKSUM_EN
  localparam int unsigned FRAME_LEN = 8;
`else
  localparam int unsigned FRAME_LEN = 7;
`endif

  // Checksum is taken over the raw values, not their ASCII encodings.
  function automatic logic [7:0] cksum_byte(input logic [7:0] s, input logic [7:0] f,
                                            input logic [7:0] a, input logic [7:0] p);
    logic [9:0] sum;
    sum = 10'(s) + 10'(f) + 10'(a) + 10'(p);
    return CH_0 + 8'(sum % 10'd10);
  endfunction

endpackage

// File: rtl/state_report_tx_if.sv
// Byte-wide valid/ready link from the report encoder toward the UART transmitter.
interface state_report_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ascii_digit_enc.sv
// Maps a selection value to its ASCII digit; out-of-range values become '?'.
module ascii_digit_enc
  import state_report_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] ascii,
  output logic       err
);

  always_comb begin
    ascii = CH_Q;
    err   = 1'b1;
    if (value >= 8'd1 && value <= 8'd9) begin
      ascii = CH_0 + value;
      err   = 1'b0;
    end
  end

endmodule

// File: rtl/state_report_tx.sv
// Snapshots the live selection and serialises "f<s><f><a><p>[ck]\r\n" one byte per handshake.
// `STATE_REPORT_CKSUM_EN inserts a mod-10 checksum digit before CR LF.
module state_report_tx
  import state_report_pkg::*;
#(
  parameter int unsigned AUTO_PERIOD = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      report_req,
  input  logic [4:0]                state,
  input  logic [7:0]                state_freq,
  input  logic [7:0]                state_amp,
  input  logic [7:0]                state_phase,
  state_report_tx_if.master         tx,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      range_err
);

  localparam logic [2:0]       LAST_IDX = 3'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_PERIOD - 1);

  fsm_e             fsm_q;
  logic [7:0]       snap_q [4];
  logic [7:0]       dig [4];
  logic [3:0]       dig_err;
  logic [2:0]       idx_q, nxt_idx;
  logic [7:0]       data_q, nxt_byte;
  logic             valid_q, done_q, err_q, pending_q;
  logic [CNT_W-1:0] cnt_q;
  logic             auto_tick, trig, start, accept;

  for (genvar i = 0; i < 4; i++) begin : g_enc
    ascii_digit_enc u_enc (
      .value (snap_q[i]),
      .ascii (dig[i]),
      .err   (dig_err[i])
    );
  end

  assign auto_tick = (AUTO_PERIOD != 0) && (cnt_q == CNT_LAST);
  assign trig      = report_req | auto_tick;
  assign accept    = valid_q & tx.tx_ready;

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign busy        = (fsm_q != StIdle) | pending_q;
  assign frame_done  = done_q;
  assign range_err   = err_q;

  // A queued request is served straight out of DONE without passing through IDLE.
  always_comb begin
    case (fsm_q)
      StIdle:  start = trig;
      StDone:  start = pending_q | trig;
      default: start = 1'b0;
    endcase
  end

  always_comb begin
    nxt_idx  = idx_q + 3'd1;
    nxt_byte = CH_LF;
    case (nxt_idx)
      3'd1: nxt_byte = dig[0];
      3'd2: nxt_byte = dig[1];
      3'd3: nxt_byte = dig[2];
      3'd4: nxt_byte = dig[3];
`ifdef STATE_REPORT_CKSUM_EN
      3'd5: nxt_byte = cksum_byte(snap_q[0], snap_q[1], snap_q[2], snap_q[3]);
      3'd6: nxt_byte = CH_CR;
`else
      3'd5: nxt_byte = CH_CR;
`endif
      default: nxt_byte = CH_LF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) snap_q[i] <= 8'h00;
    end else if (start) begin
      snap_q[0] <= {3'b000, state};
      snap_q[1] <= state_freq;
      snap_q[2] <= state_amp;
      snap_q[3] <= state_phase;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= StIdle;
      idx_q     <= 3'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fsm_q == StSend && |dig_err) err_q <= 1'b1;
      if (start) begin
        fsm_q     <= StSend;
        idx_q     <= 3'd0;
        data_q    <= CH_F;
        valid_q   <= 1'b1;
        pending_q <= 1'b0;
      end else begin
        case (fsm_q)
          StSend: begin
            if (trig) pending_q <= 1'b1;
            if (accept) begin
              if (idx_q == LAST_IDX) begin
                valid_q <= 1'b0;
                done_q  <= 1'b1;
                fsm_q   <= StDone;
              end else begin
                idx_q  <= nxt_idx;
                data_q <= nxt_byte;
              end
            end
          end
          StDone:  fsm_q <= StIdle;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (AUTO_PERIOD != 0) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_state_report_tx.sv
// Randomised self-checking bench for state_report_tx against a frame-level reference model.
module tb_state_report_tx;

`ifdef STATE_REPORT_CKSUM_EN
  localparam int FLEN = 8;
`else
  localparam int FLEN = 7;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_auto = 1'b1;
  logic       report_req = 1'b0;
  logic [4:0] st = 5'd0;
  logic [7:0] fr = 8'd0, am = 8'd0, ph = 8'd0;
  logic       ready = 1'b0;
  logic       busy, frame_done, range_err;
  logic       a_busy, a_done, a_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rmode    = 0;
  int rphase   = 0;
  int done_cnt = 0;
  int exp_err  = 0;

  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] a_rx[$];
  int         a_starts[$];
  int         a_pos = 0;

  state_report_tx_if txif ();
  state_report_tx_if aif ();

  assign txif.tx_ready = ready;
  assign aif.tx_ready  = 1'b1;

  state_report_tx dut (
    .clk         (clk),
    .rst         (rst),
    .report_req  (report_req),
    .state       (st),
    .state_freq  (fr),
    .state_amp   (am),
    .state_phase (ph),
    .tx          (txif.master),
    .busy        (busy),
    .frame_done  (frame_done),
    .range_err   (range_err)
  );

  state_report_tx #(.AUTO_PERIOD(20), .CNT_W(8)) dut_auto (
    .clk         (clk),
    .rst         (rst_auto),
    .report_req  (1'b0),
    .state       (5'd9),
    .state_freq  (8'd9),
    .state_amp   (8'd9),
    .state_phase (8'd9),
    .tx          (aif.master),
    .busy        (a_busy),
    .frame_done  (a_done),
    .range_err   (a_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame contents straight from the value rules.
  function automatic logic [7:0] dig(input int v);
    return (v >= 1 && v <= 9) ? 8'(48 + v) : 8'h3F;
  endfunction

  task automatic push_frame(input int s, input int f, input int a, input int p);
    exp_q.push_back(8'h66);
    exp_q.push_back(dig(s));
    exp_q.push_back(dig(f));
    exp_q.push_back(dig(a));
    exp_q.push_back(dig(p));
`ifdef STATE_REPORT_CKSUM_EN
    exp_q.push_back(8'(48 + (s + f + a + p) % 10));
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    if (!(s >= 1 && s <= 9) || !(f >= 1 && f <= 9) || !(a >= 1 && a <= 9) ||
        !(p >= 1 && p <= 9)) exp_err = 1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: ready = 1'b1;
      1: begin ready = (rphase == 0); rphase = (rphase + 1) % 3; end
      2: ready = ($urandom_range(0, 9) < 7);
      default: ready = 1'b0;
    endcase
  end

  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) check("hold", {txif.tx_valid, txif.tx_data}, {1'b1, hold_d});
      if (txif.tx_valid && ready) begin
        rx_q.push_back(txif.tx_data);
        rx_cyc.push_back(cyc);
      end
      if (frame_done) done_cnt++;
      hold_v = txif.tx_valid && !ready;
      hold_d = txif.tx_data;
    end
  end

  always @(negedge clk) begin
    if (!rst_auto && aif.tx_valid) begin
      a_rx.push_back(aif.tx_data);
      if (a_pos == 0) a_starts.push_back(cyc);
      a_pos = (a_pos + 1) % FLEN;
    end
  end

  task automatic set_vals(input int s, input int f, input int a, input int p);
    st = 5'(s); fr = 8'(f); am = 8'(a); ph = 8'(p);
  endtask

  task automatic pulse_req(output int c0);
    @(posedge clk); #1;
    report_req = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    report_req = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int limit);
    int k = 0;
    while (rx_q.size() < n && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    if (rx_q.size() < n) check("timeout", rx_q.size(), n);
  endtask

  task automatic cmp_frames(input string tag);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, exp_q[i]);
    rx_q.delete(); rx_cyc.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_err = 0;
    rx_q.delete(); rx_cyc.delete(); exp_q.delete();
  endtask

  initial begin
    int c0, d0, s, f, a, p;
    rmode = 0;
    @(negedge clk);
    check("rst_valid", txif.tx_valid, 0);
    check("rst_data", txif.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", range_err, 0);
    do_reset();

    // Basic frame with ready held high: back-to-back bytes, latency 1.
    set_vals(3, 1, 1, 1);
    push_frame(3, 1, 1, 1);
    d0 = done_cnt;
    pulse_req(c0);
    check("busy_on", busy, 1);
    wait_rx(FLEN, 100);
    if (rx_cyc.size() == FLEN) begin
      check("latency", rx_cyc[0], c0 + 1);
      check("b2b", rx_cyc[FLEN-1] - rx_cyc[0], FLEN - 1);
    end
    cmp_frames("t1");
    repeat (4) @(posedge clk);
    #1 check("t1_done", done_cnt - d0, 1);
    check("t1_idle", busy, 0);

    // Stalled handshake: ready one cycle in three.
    rmode = 1;
    push_frame(3, 1, 1, 1);
    pulse_req(c0);
    wait_rx(FLEN, 200);
    repeat (4) @(posedge clk);
    cmp_frames("t2");
    rmode = 0;

    // Out-of-range fields and sticky error.
    s = $urandom_range(1, 9); p = $urandom_range(1, 9);
    set_vals(s, 0, 12, p);
    push_frame(s, 0, 12, p);
    pulse_req(c0);
    wait_rx(FLEN, 100);
    repeat (3) @(posedge clk);
    cmp_frames("t3");
    #1 check("t3_err", range_err, 1);
    set_vals(5, 6, 7, 8);
    push_frame(5, 6, 7, 8);
    pulse_req(c0);
    wait_rx(FLEN, 100);
    repeat (3) @(posedge clk);
    cmp_frames("t3b");
    #1 check("t3_sticky", range_err, 1);
    do_reset();
    check("t3_clr", range_err, 0);

    // Requests mid-frame merge into exactly one follow-up frame.
    set_vals(2, 4, 6, 8);
    push_frame(2, 4, 6, 8);
    d0 = done_cnt;
    pulse_req(c0);
    wait_rx(2, 100);
    pulse_req(c0);
    set_vals(9, 7, 5, 3);
    push_frame(9, 7, 5, 3);
    wait_rx(4, 100);
    pulse_req(c0);
    wait_rx(2 * FLEN, 200);
    repeat (30) @(posedge clk);
    cmp_frames("t4");
    #1 check("t4_done", done_cnt - d0, 2);
    check("t4_idle", busy, 0);

    // Reset while a byte is pending aborts the frame.
    set_vals(1, 2, 3, 4);
    d0 = done_cnt;
    pulse_req(c0);
    wait_rx(3, 100);
    rmode = 3;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("t5_valid", txif.tx_valid, 0);
    check("t5_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rx_q.delete(); rx_cyc.delete(); exp_q.delete(); exp_err = 0;
    check("t5_nodone", done_cnt - d0, 0);
    rmode = 0;
    push_frame(1, 2, 3, 4);
    pulse_req(c0);
    wait_rx(FLEN, 100);
    repeat (3) @(posedge clk);
    cmp_frames("t5");

    // Random values and random back-pressure.
    rmode = 2;
    for (int it = 0; it < 12; it++) begin
      s = $urandom_range(0, 12); f = $urandom_range(0, 12);
      a = $urandom_range(0, 12); p = $urandom_range(0, 12);
      set_vals(s, f, a, p);
      push_frame(s, f, a, p);
      pulse_req(c0);
      set_vals($urandom_range(0, 31), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255));
      wait_rx(FLEN, 300);
      repeat (3) @(posedge clk);
      cmp_frames("rnd");
      #1 check("rnd_err", range_err, exp_err);
    end
    rmode = 0;

    // Self-triggered reports every AUTO_PERIOD clocks.
    @(posedge clk); #1 rst_auto = 1'b0;
    repeat (20 * 6 + 5) @(posedge clk);
    #1 check("auto_cnt", a_starts.size() >= 5, 1);
    for (int k = 1; k < a_starts.size(); k++)
      check("auto_period", a_starts[k] - a_starts[k-1], 20);
    push_frame(9, 9, 9, 9);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < FLEN; i++)
        check("auto_byte", (k * FLEN + i < a_rx.size()) ? {24'h0, a_rx[k*FLEN+i]} : 32'hDEAD,
              exp_q[i]);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
